// File: rtl/jk_ctrl_pkg.sv
// Shared op codes and FSM encoding for the JK bank sequencer.
// Pure constants: no latency, no backpressure.
package jk_ctrl_pkg;

    // Op encoding is {j,k} as driven onto the bank.
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Requester handshake plus JK bank drive/readback bundle.
// Wires only: no latency; req_ready is the sequencer's one-hot grant.
interface jk_bank_sequencer_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_mask;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      j;
    logic [WIDTH-1:0]      k;
    logic                  busy;
    logic                  done;
    logic [IW-1:0]         done_id;
    logic                  err;

    modport master (
        output req_valid, req_op, req_mask, q,
        input  req_ready, j, k, busy, done, done_id, err
    );

    modport slave (
        input  req_valid, req_op, req_mask, q,
        output req_ready, j, k, busy, done, done_id, err
    );

endinterface

// File: rtl/jk_bank_sequencer_rr_arbiter.sv
// Round-robin picker: first asserted req at or after ptr, wrapping.
// Combinational, zero latency; grants nothing when req is empty.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    int            pos;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int o = 0; o < NREQ; o++) begin
            pos = int'(ptr) + o;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = IW'(pos);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Arbitrates masked hold/clear/set/toggle ops onto a JK bank and verifies the result.
// Transfer-to-done latency 3 cycles; requesters are stalled (req_ready=0) while busy.
module jk_bank_sequencer #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    jk_bank_sequencer_if.slave bus
);
    import jk_ctrl_pkg::*;

    localparam int IW = $clog2(NREQ);

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] k_r;
    logic [IW-1:0]    id_r;
    logic [IW-1:0]    rr_ptr;
    logic             done_r;
    logic             err_r;
    logic [IW-1:0]    done_id_r;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_idx;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_mask;
    logic [WIDTH-1:0] op_val;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign bus.req_ready = (state == ST_IDLE) ? gnt : '0;

    always_comb begin
        sel_op   = '0;
        sel_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op   = bus.req_op[2*i +: 2];
                sel_mask = bus.req_mask[WIDTH*i +: WIDTH];
            end
        end
    end

    // Value the masked bits should take, judged from q before the capture edge.
    always_comb begin
        op_val = bus.q;
        case (op_r)
            OP_CLR:  op_val = '0;
            OP_SET:  op_val = '1;
            OP_TGL:  op_val = ~bus.q;
            default: op_val = bus.q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_r      <= '0;
            mask_r    <= '0;
            exp_r     <= '0;
            j_r       <= '0;
            k_r       <= '0;
            id_r      <= '0;
            rr_ptr    <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            done_id_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        op_r   <= sel_op;
                        mask_r <= sel_mask;
                        id_r   <= gnt_idx;
                        rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
                        // Registered drive so j/k are live for the whole ISSUE cycle.
                        j_r    <= sel_mask & {WIDTH{sel_op[1]}};
                        k_r    <= sel_mask & {WIDTH{sel_op[0]}};
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    exp_r <= (bus.q & ~mask_r) | (op_val & mask_r);
                    j_r   <= '0;
                    k_r   <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    done_r    <= 1'b1;
                    err_r     <= (bus.q != exp_r);
                    done_id_r <= id_r;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.j       = j_r;
    assign bus.k       = k_r;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.done_id = done_id_r;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench: behavioural JK bank on q/j/k, directed scenarios then random traffic vs a cycle-level model.
module tb_jk_bank_sequencer;
    import jk_ctrl_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_bank_sequencer_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    jk_bank_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Master-slave JK bank; stuck forces selected outputs to 0.
    logic [WIDTH-1:0] bank_m = '0;
    logic [WIDTH-1:0] bank_s = '0;
    logic [WIDTH-1:0] stuck  = '0;
    assign bus.q = bank_s & ~stuck;
    always @(posedge clk) bank_m <= (bus.j & ~bus.q) | (~bus.k & bus.q);
    always @(negedge clk) bank_s <= bank_m;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op, input logic [WIDTH-1:0] mask,
                                                  input logic [WIDTH-1:0] qv);
        logic [WIDTH-1:0] res;
        case (op)
            OP_CLR:  res = '0;
            OP_SET:  res = '1;
            OP_TGL:  res = ~qv;
            default: res = qv;
        endcase
        return (qv & ~mask) | (res & mask);
    endfunction

    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int ptr);
        logic [NREQ-1:0] g;
        g = '0;
        for (int o = NREQ-1; o >= 0; o--)
            if (v[(ptr + o) % NREQ]) begin
                g = '0;
                g[(ptr + o) % NREQ] = 1'b1;
            end
        return g;
    endfunction

    // Reference model state
    logic             m_inflight = 1'b0;
    int               m_age = 0;
    int               m_ptr = 0;
    int               m_id = 0;
    logic [1:0]       m_op = '0;
    logic [WIDTH-1:0] m_mask = '0;
    logic [WIDTH-1:0] m_q = '0;
    logic             m_err = 1'b0;
    int               gnt_cnt = 0;
    int               gnt_last = 0;
    int               gnt_cyc = 0;
    logic [NREQ-1:0]  gnt_now = '0;
    int               cyc = 0;

    logic             hs;
    int               hs_id;
    logic [1:0]       hs_op;
    logic [WIDTH-1:0] hs_mask;
    logic [NREQ-1:0]  exp_rdy;
    logic             done_exp;
    logic [WIDTH-1:0] ideal;

    always begin
        @(negedge clk); #1;
        hs = 1'b0;
        if (rst) begin
            m_inflight = 1'b0;
            m_ptr      = 0;
        end else begin
            exp_rdy = m_inflight ? '0 : rr_pick(bus.req_valid, m_ptr);
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            for (int i = 0; i < NREQ; i++)
                if (exp_rdy[i]) begin
                    hs      = 1'b1;
                    hs_id   = i;
                    hs_op   = bus.req_op[2*i +: 2];
                    hs_mask = bus.req_mask[WIDTH*i +: WIDTH];
                end
        end
        @(posedge clk); #1;
        cyc++;
        gnt_now = '0;
        m_q = m_q & ~stuck;
        if (rst) begin
            m_inflight = 1'b0;
            m_ptr      = 0;
        end else begin
            done_exp = 1'b0;
            if (m_inflight) begin
                m_age++;
                if (m_age == 3) begin
                    done_exp   = 1'b1;
                    m_inflight = 1'b0;
                end
            end
            if (hs) begin
                m_inflight = 1'b1;
                m_age      = 1;
                m_id       = hs_id;
                m_op       = hs_op;
                m_mask     = hs_mask;
                ideal      = apply_op(hs_op, hs_mask, m_q);
                m_q        = ideal & ~stuck;
                m_err      = (m_q != ideal);
                m_ptr      = (hs_id + 1) % NREQ;
                gnt_cnt++;
                gnt_last   = hs_id;
                gnt_cyc    = cyc;
                gnt_now[hs_id] = 1'b1;
            end
            chk("busy", 32'(bus.busy), 32'(m_inflight));
            chk("j", 32'(bus.j), (m_inflight && m_age == 1) ? 32'(m_mask & {WIDTH{m_op[1]}}) : 32'(0));
            chk("k", 32'(bus.k), (m_inflight && m_age == 1) ? 32'(m_mask & {WIDTH{m_op[0]}}) : 32'(0));
            chk("done", 32'(bus.done), 32'(done_exp));
            if (done_exp) begin
                chk("done_id", 32'(bus.done_id), 32'(m_id));
                chk("err", 32'(bus.err), 32'(m_err));
                chk("q_at_done", 32'(bus.q), 32'(m_q));
            end
        end
    end

    task automatic set_req(input int id, input logic [1:0] op, input logic [WIDTH-1:0] mask);
        bus.req_valid[id]            = 1'b1;
        bus.req_op[2*id +: 2]        = op;
        bus.req_mask[WIDTH*id +: WIDTH] = mask;
    endtask

    task automatic wait_gnt(output int waited);
        int c0;
        c0     = gnt_cnt;
        waited = 0;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk); #2;
            if (gnt_cnt != c0) begin
                waited = t;
                break;
            end
        end
        chk("grant_seen", 32'(gnt_cnt != c0), 32'(1));
    endtask

    // Starts just after a posedge; returns 2 units after the done-cycle posedge.
    task automatic do_op(input int id, input logic [1:0] op, input logic [WIDTH-1:0] mask,
                         input logic [WIDTH-1:0] exp_q, input logic exp_err, output int waited);
        set_req(id, op, mask);
        wait_gnt(waited);
        bus.req_valid[id] = 1'b0;
        chk("issue_busy", 32'(bus.busy), 32'(1));
        chk("issue_j", 32'(bus.j), 32'(mask & {WIDTH{op[1]}}));
        chk("issue_k", 32'(bus.k), 32'(mask & {WIDTH{op[0]}}));
        @(posedge clk); #2;
        chk("settle_jk", 32'({bus.j, bus.k}), 32'(0));
        chk("settle_done", 32'(bus.done), 32'(0));
        @(posedge clk); #2;
        chk("op_done", 32'(bus.done), 32'(1));
        chk("op_done_id", 32'(bus.done_id), 32'(id));
        chk("op_err", 32'(bus.err), 32'(exp_err));
        chk("op_q", 32'(bus.q), 32'(exp_q));
        chk("op_idle", 32'(bus.busy), 32'(0));
    endtask

    initial begin
        int w;
        int prev_cyc;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_mask  = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_j", 32'(bus.j), 32'(0));
        chk("rst_k", 32'(bus.k), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_err", 32'(bus.err), 32'(0));
        chk("rst_done_id", 32'(bus.done_id), 32'(0));
        chk("rst_ready", 32'(bus.req_ready), 32'(0));
        rst = 1'b0;

        do_op(0, OP_SET,  8'h0F, 8'h0F, 1'b0, w);
        chk("first_grant_wait", 32'(w), 32'(1));
        do_op(1, OP_TGL,  8'hFF, 8'hF0, 1'b0, w);
        do_op(2, OP_HOLD, 8'hFF, 8'hF0, 1'b0, w);

        // Stuck-at-0 on bit 7: set of that bit must be flagged.
        stuck = 8'h80;
        do_op(3, OP_SET, 8'h80, 8'h70, 1'b1, w);
        repeat (3) @(posedge clk);
        #2;
        stuck = 8'h00;

        // Abort during SETTLE.
        set_req(1, OP_TGL, 8'h0F);
        wait_gnt(w);
        bus.req_valid[1] = 1'b0;
        @(posedge clk); #2;
        chk("abort_pre_busy", 32'(bus.busy), 32'(1));
        #1 rst = 1'b1;
        #1;
        chk("abort_j", 32'(bus.j), 32'(0));
        chk("abort_k", 32'(bus.k), 32'(0));
        chk("abort_busy", 32'(bus.busy), 32'(0));
        repeat (2) begin
            @(posedge clk); #2;
            chk("abort_no_done", 32'(bus.done), 32'(0));
        end
        for (int i = 0; i < NREQ; i++) set_req(i, OP_HOLD, 8'hFF);
        rst = 1'b0;

        // All requesters valid continuously.
        prev_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(w);
            chk("rr_order", 32'(gnt_last), 32'(g % NREQ));
            if (g > 0) chk("rr_spacing", 32'(gnt_cyc - prev_cyc), 32'(3));
            prev_cyc = gnt_cyc;
        end
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #2;

        // Back-to-back: second request raised during the first one's done cycle.
        do_op(2, OP_TGL, 8'h3C, 8'h43, 1'b0, w);
        do_op(1, OP_CLR, 8'hFF, 8'h00, 1'b0, w);
        chk("b2b_same_cycle_grant", 32'(w), 32'(1));

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i]) begin
                    if (gnt_now[i]) begin
                        if ($urandom_range(1) == 0) bus.req_valid[i] = 1'b0;
                        else set_req(i, 2'($urandom_range(3)), 8'($urandom));
                    end else if ($urandom_range(15) == 0) begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(3) == 0) begin
                    set_req(i, 2'($urandom_range(3)), 8'($urandom));
                end
            end
        end
        bus.req_valid = '0;
        repeat (6) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
